// File: rtl/sale_terminal_pkg.sv
// Shared definitions for the sale terminal keypad path: key codes,
// scanner state encoding and small decode helpers.
package sale_terminal_pkg;

    localparam logic [3:0] KEY_A     = 4'd10;
    localparam logic [3:0] KEY_B     = 4'd11;
    localparam logic [3:0] KEY_C     = 4'd12;
    localparam logic [3:0] KEY_D     = 4'd13;
    localparam logic [3:0] KEY_STAR  = 4'd14;
    localparam logic [3:0] KEY_HASH  = 4'd15;
    // Blank shares the C code; the display treats it as "nothing entered".
    localparam logic [3:0] KEY_BLANK = 4'd12;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    // Physical keypad layout: row/column position to key code.
    function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_BLANK;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            4'hF:    code = KEY_D;
            default: code = KEY_BLANK;
        endcase
        return code;
    endfunction

    // Lowest-index active-low column wins when several are pressed.
    function automatic logic [1:0] lowest_col_f(input logic [3:0] col_n);
        logic [1:0] idx;
        if (!col_n[0]) begin
            idx = 2'd0;
        end else if (!col_n[1]) begin
            idx = 2'd1;
        end else if (!col_n[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Active-low one-hot row drive pattern.
    function automatic logic [3:0] row_drive_f(input logic [1:0] row);
        logic [3:0] drive;
        case (row)
            2'd0:    drive = 4'b1110;
            2'd1:    drive = 4'b1101;
            2'd2:    drive = 4'b1011;
            2'd3:    drive = 4'b0111;
            default: drive = 4'b1110;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
// Resets to all ones so an idle keypad is seen during and after reset.
module keypad_col_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] col_n_i,
    output logic [3:0] col_n_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Double-register the raw column lines into the clock domain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= col_n_i;
            sync_q <= meta_q;
        end
    end

    assign col_n_o = sync_q;

endmodule

// File: rtl/keypad_digit_scanner.sv
// 4x4 keypad scanner: walks the rows, debounces a press on the latched
// column, emits one pulse per accepted key and waits for a debounced release.
module keypad_digit_scanner
    import sale_terminal_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [3:0] Col_n,
    output logic [3:0] Row_n,
    output logic [3:0] Key_code,
    output logic       Digit_valid,
    output logic       Cmd_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_CYCLES);

    logic [3:0]       col_sync_s;
    scan_state_t      state_q;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [3:0]       row_n_q;
    logic [3:0]       key_code_q;
    logic             digit_valid_q;
    logic             cmd_valid_q;

    keypad_col_sync u_col_sync (
        .clk_i   (CLOCK),
        .rst_n_i (RESET_N),
        .col_n_i (Col_n),
        .col_n_o (col_sync_s)
    );

    // Scanner FSM with row drive, counters and registered key outputs.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_SCAN;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            div_cnt_q     <= '0;
            deb_cnt_q     <= '0;
            row_n_q       <= 4'b1110;
            key_code_q    <= KEY_BLANK;
            digit_valid_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
        end else begin
            // Pulses only live for the single EMIT cycle.
            digit_valid_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (col_sync_s != 4'b1111) begin
                            // Freeze the row and chase this column.
                            col_q     <= lowest_col_f(col_sync_s);
                            deb_cnt_q <= '0;
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            row_q   <= row_q + 2'd1;
                            row_n_q <= row_drive_f(row_q + 2'd1);
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col_sync_s[col_q]) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            deb_cnt_q  <= DEB_FULL;
                            key_code_q <= key_code_f(row_q, col_q);
                            if (key_code_f(row_q, col_q) < 4'd10) begin
                                digit_valid_q <= 1'b1;
                            end else begin
                                cmd_valid_q <= 1'b1;
                            end
                            state_q <= ST_EMIT;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end
                    end else begin
                        // Bounce or glitch: drop it and carry on with the next row.
                        deb_cnt_q <= '0;
                        div_cnt_q <= '0;
                        row_q     <= row_q + 2'd1;
                        row_n_q   <= row_drive_f(row_q + 2'd1);
                        state_q   <= ST_SCAN;
                    end
                end
                ST_EMIT: begin
                    deb_cnt_q <= '0;
                    state_q   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (col_sync_s == 4'b1111) begin
                        if (deb_cnt_q == DEB_LAST) begin
                            deb_cnt_q <= '0;
                            div_cnt_q <= '0;
                            row_q     <= 2'd0;
                            row_n_q   <= 4'b1110;
                            state_q   <= ST_SCAN;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_SCAN;
                    row_q     <= 2'd0;
                    div_cnt_q <= '0;
                    deb_cnt_q <= '0;
                    row_n_q   <= 4'b1110;
                end
            endcase
        end
    end

    assign Row_n       = row_n_q;
    assign Key_code    = key_code_q;
    assign Digit_valid = digit_valid_q;
    assign Cmd_valid   = cmd_valid_q;

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Directed bench for keypad_digit_scanner with a small 4x4 switch-matrix model.
module tb_keypad_digit_scanner;

    logic       CLOCK;
    logic       RESET_N;
    logic [3:0] Col_n;
    logic [3:0] Row_n;
    logic [3:0] Key_code;
    logic       Digit_valid;
    logic       Cmd_valid;

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] keys;

    int chk_total = 0;
    int chk_pass  = 0;
    int dig_cnt   = 0;
    int cmd_cnt   = 0;
    int both_cnt  = 0;

    keypad_digit_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .Col_n       (Col_n),
        .Row_n       (Row_n),
        .Key_code    (Key_code),
        .Digit_valid (Digit_valid),
        .Cmd_valid   (Cmd_valid)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Switch matrix: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        Col_n = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[r*4+c] && !Row_n[r]) Col_n[c] = 1'b0;
            end
        end
    end

    // Pulse monitor sampled away from the active edge.
    always @(negedge CLOCK) begin
        if (Digit_valid) dig_cnt++;
        if (Cmd_valid) cmd_cnt++;
        if (Digit_valid && Cmd_valid) both_cnt++;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        keys = 16'h0000;
        wait_cycles(3);
        chk_total++; if (Row_n !== 4'b1110) $display("FAIL reset_row: got %b expected 1110", Row_n); else chk_pass++;
        chk_total++; if (Key_code !== 4'd12) $display("FAIL reset_key: got %0d expected 12", Key_code); else chk_pass++;
        chk_total++; if (Digit_valid !== 1'b0) $display("FAIL reset_dv: got %b expected 0", Digit_valid); else chk_pass++;
        chk_total++; if (Cmd_valid !== 1'b0) $display("FAIL reset_cv: got %b expected 0", Cmd_valid); else chk_pass++;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_row;
        int d0;
        int c0;
        d0 = dig_cnt; c0 = cmd_cnt;
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            case ((i / 4) % 4)
                0: exp_row = 4'b1110;
                1: exp_row = 4'b1101;
                2: exp_row = 4'b1011;
                default: exp_row = 4'b0111;
            endcase
            chk_total++; if (Row_n !== exp_row) $display("FAIL idle_row[%0d]: got %b expected %b", i, Row_n, exp_row); else chk_pass++;
            @(negedge CLOCK);
        end
        chk_total++; if ((dig_cnt - d0) + (cmd_cnt - c0) != 0) $display("FAIL idle_pulses: got %0d expected 0", (dig_cnt - d0) + (cmd_cnt - c0)); else chk_pass++;
        chk_total++; if (Key_code !== 4'd12) $display("FAIL idle_key: got %0d expected 12", Key_code); else chk_pass++;
    endtask

    task automatic test_digit_five();
        int d0;
        int c0;
        d0 = dig_cnt; c0 = cmd_cnt;
        keys[1*4+1] = 1'b1;
        wait_cycles(40);
        keys[1*4+1] = 1'b0;
        wait_cycles(9);
        chk_total++; if (Row_n !== 4'b1101) $display("FAIL five_frozen: got %b expected 1101", Row_n); else chk_pass++;
        wait_cycles(1);
        chk_total++; if (Row_n !== 4'b1110) $display("FAIL five_resume: got %b expected 1110", Row_n); else chk_pass++;
        wait_cycles(4);
        chk_total++; if (Row_n !== 4'b1101) $display("FAIL five_next_row: got %b expected 1101", Row_n); else chk_pass++;
        wait_cycles(16);
        chk_total++; if (dig_cnt - d0 != 1) $display("FAIL five_dv_count: got %0d expected 1", dig_cnt - d0); else chk_pass++;
        chk_total++; if (cmd_cnt - c0 != 0) $display("FAIL five_cv_count: got %0d expected 0", cmd_cnt - c0); else chk_pass++;
        chk_total++; if (Key_code !== 4'd5) $display("FAIL five_key: got %0d expected 5", Key_code); else chk_pass++;
    endtask

    task automatic test_cmd_hash();
        int d0;
        int c0;
        d0 = dig_cnt; c0 = cmd_cnt;
        keys[3*4+2] = 1'b1;
        wait_cycles(40);
        keys[3*4+2] = 1'b0;
        wait_cycles(20);
        chk_total++; if (cmd_cnt - c0 != 1) $display("FAIL hash_cv_count: got %0d expected 1", cmd_cnt - c0); else chk_pass++;
        chk_total++; if (dig_cnt - d0 != 0) $display("FAIL hash_dv_count: got %0d expected 0", dig_cnt - d0); else chk_pass++;
        chk_total++; if (Key_code !== 4'd15) $display("FAIL hash_key: got %0d expected 15", Key_code); else chk_pass++;
    endtask

    task automatic test_glitch();
        logic [3:0] prev;
        bit found;
        int d0;
        int c0;
        d0 = dig_cnt; c0 = cmd_cnt;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = Row_n;
            @(negedge CLOCK);
            if (Row_n == 4'b1011 && prev != 4'b1011) found = 1'b1;
        end
        chk_total++; if (!found) $display("FAIL glitch_row2_wait: got timeout expected row 1011 within 40 cycles"); else chk_pass++;
        keys[2*4+0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLOCK);
            if (i == 3) keys[2*4+0] = 1'b0;
            if (i == 5) begin
                chk_total++; if (Row_n !== 4'b1011) $display("FAIL glitch_frozen: got %b expected 1011", Row_n); else chk_pass++;
            end
            if (i == 6) begin
                chk_total++; if (Row_n !== 4'b0111) $display("FAIL glitch_next_row: got %b expected 0111", Row_n); else chk_pass++;
            end
        end
        chk_total++; if (Row_n !== 4'b1110) $display("FAIL glitch_wrap: got %b expected 1110", Row_n); else chk_pass++;
        chk_total++; if ((dig_cnt - d0) + (cmd_cnt - c0) != 0) $display("FAIL glitch_pulses: got %0d expected 0", (dig_cnt - d0) + (cmd_cnt - c0)); else chk_pass++;
        chk_total++; if (Key_code !== 4'd15) $display("FAIL glitch_key: got %0d expected 15", Key_code); else chk_pass++;
    endtask

    task automatic test_multi_column();
        int d0;
        d0 = dig_cnt;
        keys[0*4+1] = 1'b1;
        keys[0*4+3] = 1'b1;
        wait_cycles(40);
        keys[0*4+1] = 1'b0;
        keys[0*4+3] = 1'b0;
        wait_cycles(20);
        chk_total++; if (Key_code !== 4'd2) $display("FAIL multi_key: got %0d expected 2", Key_code); else chk_pass++;
        chk_total++; if (dig_cnt - d0 != 1) $display("FAIL multi_dv_count: got %0d expected 1", dig_cnt - d0); else chk_pass++;
    endtask

    task automatic test_reset_in_release();
        int d0;
        keys[2*4+1] = 1'b1;
        wait_cycles(40);
        chk_total++; if (Key_code !== 4'd8) $display("FAIL rr_key_before: got %0d expected 8", Key_code); else chk_pass++;
        RESET_N = 1'b0;
        #1;
        chk_total++; if (Row_n !== 4'b1110) $display("FAIL rr_row_reset: got %b expected 1110", Row_n); else chk_pass++;
        chk_total++; if (Key_code !== 4'd12) $display("FAIL rr_key_reset: got %0d expected 12", Key_code); else chk_pass++;
        wait_cycles(3);
        d0 = dig_cnt;
        RESET_N = 1'b1;
        wait_cycles(50);
        chk_total++; if (dig_cnt - d0 != 1) $display("FAIL rr_reaccept_count: got %0d expected 1", dig_cnt - d0); else chk_pass++;
        chk_total++; if (Key_code !== 4'd8) $display("FAIL rr_key_after: got %0d expected 8", Key_code); else chk_pass++;
        chk_total++; if (Row_n !== 4'b1011) $display("FAIL rr_row_held: got %b expected 1011", Row_n); else chk_pass++;
        keys[2*4+1] = 1'b0;
        wait_cycles(20);
    endtask

    initial begin
        RESET_N = 1'b0;
        keys = 16'h0000;
        test_reset();
        test_idle_scan();
        test_digit_five();
        test_cmd_hash();
        test_glitch();
        test_multi_column();
        test_reset_in_release();
        chk_total++; if (both_cnt != 0) $display("FAIL both_valid: got %0d expected 0", both_cnt); else chk_pass++;
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/keypad_digit_scanner.md
KEYPAD_DIGIT_SCANNER -- requirements
Module: keypad_digit_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each row is driven per scan slot (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 SHALL have port CLOCK, input, 1 bit, single system clock (CLOCK_50); all logic is on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit; reset is asynchronous, active-low.
REQ-005 SHALL have port Col_n, input, 4 bits, keypad columns, active-low, asynchronous to CLOCK.
REQ-006 SHALL have port Row_n, output, 4 bits, keypad row drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port Key_code, output, 4 bits, code of the last accepted key, held until the next accept.
REQ-008 SHALL have port Digit_valid, output, 1 bit, one-cycle pulse when the accepted key is 0-9; feeds the barcode shift register ENABLE, with Key_code on Digit_in.
REQ-009 SHALL have port Cmd_valid, output, 1 bit, one-cycle pulse when the accepted key is a command key (code 10-15).

Function
REQ-010 SHALL pass Col_n through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-011 SHALL map the key at row r, column c to these codes: row0 = 1,2,3,A(10); row1 = 4,5,6,B(11); row2 = 7,8,9,C(12); row3 = *(14),0,#(15),D(13).
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, EMIT and RELEASE.
REQ-013 In SCAN, SHALL drive row r low for SCAN_DIV cycles, then advance r to (r+1) mod 4, wrapping 3->0.
REQ-014 SHALL sample the synchronized columns on the last cycle of each row slot; if any column is low, SHALL latch row and column and go to DEBOUNCE with Row_n frozen.
REQ-015 If several columns are low in one sample, SHALL select the lowest column index.
REQ-016 In DEBOUNCE, SHALL count cycles in which the latched column stays low, saturating at DEBOUNCE_CYCLES.
REQ-017 If the latched column goes high before the count reaches DEBOUNCE_CYCLES, SHALL return to SCAN at the next row with no output pulse.
REQ-018 When the count reaches DEBOUNCE_CYCLES, SHALL go to EMIT.
REQ-019 In EMIT (exactly 1 cycle), SHALL update Key_code, assert exactly one of Digit_valid/Cmd_valid, then go to RELEASE.
REQ-020 In RELEASE, SHALL keep the row frozen and return to SCAN at row 0 only after all columns are high for DEBOUNCE_CYCLES consecutive cycles; any low column restarts the count.
REQ-021 A held key SHALL produce exactly one pulse, with no auto-repeat.
REQ-022 Digit_valid and Cmd_valid SHALL never both be high, and neither SHALL be high outside EMIT.
REQ-023 Counter widths SHALL be $clog2 of the parameter plus 1; counters SHALL not wrap.

Reset
REQ-024 Asserting RESET_N low SHALL immediately set state SCAN, row 0, and both counters to 0.
REQ-025 During reset, outputs SHALL be Row_n = 4'b1110, Key_code = 12 (blank), Digit_valid = 0, Cmd_valid = 0, and the synchronizer flops SHALL be all ones.
REQ-026 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the pending key; the first scan after release is a fresh scan from row 0.

Structure
REQ-027 A shared package sale_terminal_pkg SHALL hold the key-code constants (KEY_A..KEY_HASH, KEY_BLANK = 12) and the scanner state enumeration.
REQ-028 The 2-flop column synchronizer SHALL be a sub-module, keypad_col_sync, 4 bits wide with asynchronous active-low reset; everything else is in one module.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-029 Bench SHALL cover: reset release, no key -> Row_n cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; no pulses; Key_code = 12.
REQ-030 Bench SHALL cover: key "5" (row1, col1) held 40 cycles, then released -> exactly one Digit_valid pulse, Key_code = 5, Cmd_valid = 0; scanning resumes at row 0 after 8 clear cycles.
REQ-031 Bench SHALL cover: key "#" (row3, col2) pressed -> one Cmd_valid pulse, Key_code = 15.
REQ-032 Bench SHALL cover: 3-cycle glitch on row2, col0 -> no pulse; scan continues at row 3.
REQ-033 Bench SHALL cover: row0, columns 1 and 3 low together -> Key_code = 2.
REQ-034 Bench SHALL cover: RESET_N low during RELEASE with the key still held -> Row_n = 1110 and Key_code = 12 immediately; after reset, the still-held key is re-accepted once.
